// File: rtl/mem_wb_stage_pkg.sv
// Shared widths and load-op encodings for the MEM/WB writeback path.
package mem_wb_stage_pkg;

  localparam int unsigned REG_BUS_W    = 32;
  localparam int unsigned REG_ADDR_W   = 5;
  localparam int unsigned RETIRE_CNT_W = 32;
  localparam int unsigned LOAD_OP_W    = 3;

  // Load-op codes carried down from decode; unlisted codes behave as LW.
  typedef enum logic [LOAD_OP_W-1:0] {
    LOAD_LW  = 3'b000,
    LOAD_LB  = 3'b001,
    LOAD_LBU = 3'b010,
    LOAD_LH  = 3'b011,
    LOAD_LHU = 3'b100
  } load_op_e;

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// Big-endian load lane extraction, sign/zero extension and alignment check.
module load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = REG_BUS_W
) (
  input  logic [LOAD_OP_W-1:0] load_op,
  input  logic [1:0]           addr_lo,
  input  logic [DATA_W-1:0]    rdata,
  output logic [DATA_W-1:0]    data_c,
  output logic                 fault_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Byte 0 is the most significant byte of the word.
  always_comb begin
    byte_lane = 8'(rdata >> (DATA_W - 32'd8 - {27'd0, addr_lo, 3'b000}));
    half_lane = 16'(rdata >> (DATA_W - 32'd16 - {27'd0, addr_lo[1], 4'b0000}));
  end

  // Select and extend by op; any misaligned access returns zero data.
  always_comb begin
    data_c  = rdata;
    fault_c = 1'b0;
    case (load_op_e'(load_op))
      LOAD_LB:  data_c = {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      LOAD_LBU: data_c = {{(DATA_W-8){1'b0}}, byte_lane};
      LOAD_LH: begin
        fault_c = addr_lo[0];
        data_c  = {{(DATA_W-16){half_lane[15]}}, half_lane};
      end
      LOAD_LHU: begin
        fault_c = addr_lo[0];
        data_c  = {{(DATA_W-16){1'b0}}, half_lane};
      end
      default:  fault_c = (addr_lo != 2'b00);
    endcase
    if (fault_c) begin
      data_c = '0;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: formats load data, drives the GPR write port
// and counts retired instructions.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W = REG_BUS_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter int unsigned CNT_W  = RETIRE_CNT_W
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 mem_valid,
  input  logic                 mem_we,
  input  logic [ADDR_W-1:0]    mem_waddr,
  input  logic [DATA_W-1:0]    mem_alu,
  input  logic                 mem_is_load,
  input  logic [LOAD_OP_W-1:0] mem_load_op,
  input  logic [1:0]           mem_addr_lo,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 wb_we,
  output logic [ADDR_W-1:0]    wb_waddr,
  output logic [DATA_W-1:0]    wb_wdata,
  output logic                 wb_misalign,
  output logic [CNT_W-1:0]     retired
);

  logic              valid_q;
  logic [DATA_W-1:0] load_data_c;
  logic              load_fault_c;
  logic [DATA_W-1:0] result_c;
  logic              fault_c;

  load_align #(
    .DATA_W (DATA_W)
  ) u_load_align (
    .load_op (mem_load_op),
    .addr_lo (mem_addr_lo),
    .rdata   (mem_rdata),
    .data_c  (load_data_c),
    .fault_c (load_fault_c)
  );

  // Pick the writeback value; alignment faults only exist for loads.
  always_comb begin
    result_c = mem_alu;
    fault_c  = 1'b0;
    if (mem_is_load) begin
      result_c = load_data_c;
      fault_c  = load_fault_c;
    end
  end

  // Pipeline register: flush beats stall beats capture.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      valid_q     <= 1'b0;
      wb_we       <= 1'b0;
      wb_waddr    <= '0;
      wb_wdata    <= '0;
      wb_misalign <= 1'b0;
      retired     <= '0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      wb_we       <= 1'b0;
      wb_misalign <= 1'b0;
    end else if (stall) begin
      // Holding the write enable just rewrites the same value; the fault
      // flag must still drop so it stays a single-cycle pulse.
      wb_misalign <= 1'b0;
    end else begin
      valid_q     <= mem_valid;
      wb_we       <= mem_valid & mem_we & (mem_waddr != '0) & ~fault_c;
      wb_waddr    <= mem_waddr;
      wb_wdata    <= result_c;
      wb_misalign <= mem_valid & fault_c;
      if (mem_valid) begin
        retired <= retired + CNT_W'(1);
      end
    end
  end

  // A write or fault pulse only ever belongs to a real instruction.
  a_we_valid : assert property (@(posedge clk) disable iff (clr) wb_we |-> valid_q);
  a_mis_valid : assert property (@(posedge clk) disable iff (clr) wb_misalign |-> valid_q);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: vector table, directed corner sequences and
// random traffic checked against a byte-array reference model.
module tb_mem_wb_stage;

  localparam logic [31:0] RD = 32'h80FF7F01;
  localparam int NV = 15;

  logic        clk = 1'b0;
  logic        clr, stall, flush;
  logic        mem_valid, mem_we, mem_is_load;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_alu, mem_rdata;
  logic [2:0]  mem_load_op;
  logic [1:0]  mem_addr_lo;

  logic        wb_we, wb_misalign;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata, retired;

  logic        s_we, s_misalign;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_retired;

  // reference model state
  logic        m_we, m_mis;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_ret;
  logic [3:0]  m_ret_small;

  int errors, checks;

  typedef struct {
    logic        is_load;
    logic [2:0]  op;
    logic [1:0]  lo;
    logic [4:0]  waddr;
    logic [31:0] alu;
    logic [31:0] rdata;
    logic [31:0] exp_wdata;
    logic        exp_we;
    logic        exp_mis;
  } vec_t;

  vec_t tv [NV];

  always #5 clk = ~clk;

  mem_wb_stage u_dut (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_alu(mem_alu), .mem_is_load(mem_is_load), .mem_load_op(mem_load_op),
    .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .wb_misalign(wb_misalign), .retired(retired)
  );

  // Narrow counter instance so wrap-around is reachable in a short run.
  mem_wb_stage #(.CNT_W(4)) u_small (
    .clk(clk), .clr(clr), .stall(stall), .flush(flush),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_alu(mem_alu), .mem_is_load(mem_is_load), .mem_load_op(mem_load_op),
    .mem_addr_lo(mem_addr_lo), .mem_rdata(mem_rdata),
    .wb_we(s_we), .wb_waddr(s_waddr), .wb_wdata(s_wdata),
    .wb_misalign(s_misalign), .retired(s_retired)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Word viewed as four big-endian bytes; lanes picked by index.
  function automatic void ref_format(input logic [2:0] op, input logic [1:0] lo,
                                     input logic [31:0] w,
                                     output logic [31:0] d, output logic f);
    logic [7:0]  b [4];
    logic [15:0] h;
    for (int k = 0; k < 4; k++) b[k] = 8'(w >> (24 - 8 * k));
    h = {b[{lo[1], 1'b0}], b[{lo[1], 1'b1}]};
    f = 1'b0;
    d = w;
    case (op)
      3'b001: d = 32'($signed(b[lo]));
      3'b010: d = 32'(b[lo]);
      3'b011: if (lo[0]) f = 1'b1; else d = 32'($signed(h));
      3'b100: if (lo[0]) f = 1'b1; else d = 32'(h);
      default: if (lo != 2'd0) f = 1'b1;
    endcase
    if (f) d = 32'h0;
  endfunction

  task automatic model_reset();
    m_we = 0; m_mis = 0; m_waddr = 0; m_wdata = 0; m_ret = 0; m_ret_small = 0;
  endtask

  task automatic ref_edge();
    logic [31:0] d;
    logic        f;
    if (flush) begin
      m_we = 0; m_mis = 0;
    end else if (stall) begin
      m_mis = 0;
    end else begin
      ref_format(mem_load_op, mem_addr_lo, mem_rdata, d, f);
      if (!mem_is_load) begin d = mem_alu; f = 1'b0; end
      m_we    = mem_valid && mem_we && (mem_waddr != 0) && !f;
      m_waddr = mem_waddr;
      m_wdata = d;
      m_mis   = mem_valid && f;
      if (mem_valid) begin
        m_ret       = m_ret + 1;
        m_ret_small = m_ret_small + 4'd1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " we"},      32'(wb_we),       32'(m_we));
    chk({tag, " waddr"},   32'(wb_waddr),    32'(m_waddr));
    chk({tag, " wdata"},   wb_wdata,         m_wdata);
    chk({tag, " mis"},     32'(wb_misalign), 32'(m_mis));
    chk({tag, " retired"}, retired,          m_ret);
    chk({tag, " ret4"},    32'(s_retired),   32'(m_ret_small));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    ref_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive_alu(input logic [4:0] wa, input logic [31:0] v);
    mem_valid = 1; mem_we = 1; mem_is_load = 0; mem_waddr = wa; mem_alu = v;
    mem_load_op = 3'b000; mem_addr_lo = 2'd0; mem_rdata = 32'h0;
  endtask

  task automatic drive_load(input logic [2:0] op, input logic [1:0] lo,
                            input logic [4:0] wa, input logic [31:0] w);
    mem_valid = 1; mem_we = 1; mem_is_load = 1; mem_waddr = wa; mem_alu = 32'h0;
    mem_load_op = op; mem_addr_lo = lo; mem_rdata = w;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [31:0] ret_save;
    errors = 0; checks = 0;

    //          ld    op      lo   wa    alu           rdata exp_wdata      we    mis
    tv[0]  = '{1'b1, 3'b001, 2'd0, 5'd7, 32'h0,        RD, 32'hFFFFFF80, 1'b1, 1'b0};
    tv[1]  = '{1'b1, 3'b010, 2'd1, 5'd7, 32'h0,        RD, 32'h000000FF, 1'b1, 1'b0};
    tv[2]  = '{1'b1, 3'b011, 2'd2, 5'd7, 32'h0,        RD, 32'h00007F01, 1'b1, 1'b0};
    tv[3]  = '{1'b1, 3'b100, 2'd0, 5'd7, 32'h0,        RD, 32'h000080FF, 1'b1, 1'b0};
    tv[4]  = '{1'b1, 3'b000, 2'd0, 5'd7, 32'h0,        RD, 32'h80FF7F01, 1'b1, 1'b0};
    tv[5]  = '{1'b1, 3'b001, 2'd2, 5'd8, 32'h0,        RD, 32'h0000007F, 1'b1, 1'b0};
    tv[6]  = '{1'b1, 3'b001, 2'd3, 5'd8, 32'h0,        RD, 32'h00000001, 1'b1, 1'b0};
    tv[7]  = '{1'b1, 3'b011, 2'd0, 5'd8, 32'h0,        RD, 32'hFFFF80FF, 1'b1, 1'b0};
    tv[8]  = '{1'b1, 3'b000, 2'd2, 5'd7, 32'h0,        RD, 32'h00000000, 1'b0, 1'b1};
    tv[9]  = '{1'b1, 3'b011, 2'd1, 5'd9, 32'h0,        RD, 32'h00000000, 1'b0, 1'b1};
    tv[10] = '{1'b1, 3'b100, 2'd3, 5'd9, 32'h0,        RD, 32'h00000000, 1'b0, 1'b1};
    tv[11] = '{1'b0, 3'b000, 2'd0, 5'd5, 32'h12345678, RD, 32'h12345678, 1'b1, 1'b0};
    tv[12] = '{1'b0, 3'b000, 2'd0, 5'd0, 32'hDEADBEEF, RD, 32'hDEADBEEF, 1'b0, 1'b0};
    tv[13] = '{1'b1, 3'b111, 2'd0, 5'd3, 32'h0,        RD, 32'h80FF7F01, 1'b1, 1'b0};
    tv[14] = '{1'b1, 3'b010, 2'd3, 5'd3, 32'h0,        RD, 32'h00000001, 1'b1, 1'b0};

    // reset state
    clr = 1; stall = 0; flush = 0;
    drive_alu(5'd0, 32'h0); mem_valid = 0; mem_we = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); clr = 0;

    // vector table
    for (int i = 0; i < NV; i++) begin
      mem_valid = 1; mem_we = 1;
      mem_is_load = tv[i].is_load; mem_load_op = tv[i].op; mem_addr_lo = tv[i].lo;
      mem_waddr = tv[i].waddr; mem_alu = tv[i].alu; mem_rdata = tv[i].rdata;
      @(posedge clk);
      ref_edge();
      #1;
      chk($sformatf("vec%0d wdata", i), wb_wdata, tv[i].exp_wdata);
      chk($sformatf("vec%0d we", i), 32'(wb_we), 32'(tv[i].exp_we));
      chk($sformatf("vec%0d mis", i), 32'(wb_misalign), 32'(tv[i].exp_mis));
      chk($sformatf("vec%0d waddr", i), 32'(wb_waddr), 32'(tv[i].waddr));
      chk($sformatf("vec%0d retired", i), retired, m_ret);
    end

    // async reset with a write pending
    drive_alu(5'd9, 32'hCAFEF00D);
    cyc("pre_rst");
    #2; clr = 1; #1;
    model_reset();
    check_all("mid_rst");
    @(negedge clk); clr = 0;
    drive_alu(5'd3, 32'h00001111);
    cyc("post_rst");
    chk("post_rst count", retired, 32'd1);

    // misalign pulse followed by a stall: pulse must drop
    drive_load(3'b000, 2'd2, 5'd7, RD);
    cyc("mis_set");
    chk("mis_set pulse", 32'(wb_misalign), 32'd1);
    stall = 1;
    cyc("mis_stall");
    chk("mis_one_cycle", 32'(wb_misalign), 32'd0);
    stall = 0;

    // three-cycle stall holds everything
    drive_alu(5'd4, 32'hA5A5A5A5);
    cyc("pre_stall");
    ret_save = retired;
    stall = 1;
    drive_alu(5'd6, 32'h11111111);
    for (int k = 0; k < 3; k++) begin
      cyc("stall");
      chk("stall_hold wdata", wb_wdata, 32'hA5A5A5A5);
      chk("stall_hold we", 32'(wb_we), 32'd1);
      chk("stall_hold retired", retired, ret_save);
    end

    // stall and flush together bubble
    flush = 1;
    cyc("stall_flush");
    chk("stall_flush we", 32'(wb_we), 32'd0);
    chk("stall_flush retired", retired, ret_save);
    stall = 0;
    cyc("flush_only");
    flush = 0;
    drive_alu(5'd0, 32'hDEADBEEF);
    cyc("zero_reg");
    chk("zero_reg we", 32'(wb_we), 32'd0);

    // counter wrap on the narrow instance
    drive_alu(5'd2, 32'h00000022);
    for (int k = 0; k < 20 && m_ret_small != 4'hF; k++) cyc("to_wrap");
    chk("pre_wrap", 32'(s_retired), 32'hF);
    cyc("wrap");
    chk("wrap", 32'(s_retired), 32'h0);

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      stall       = ($urandom_range(0, 7) == 0);
      flush       = ($urandom_range(0, 9) == 0);
      mem_valid   = ($urandom_range(0, 3) != 0);
      mem_we      = ($urandom_range(0, 4) != 0);
      mem_waddr   = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      mem_alu     = $urandom;
      mem_is_load = $urandom_range(0, 1) == 1;
      mem_load_op = 3'($urandom_range(0, 7));
      mem_addr_lo = 2'($urandom);
      mem_rdata   = $urandom;
      cyc($sformatf("rand%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and writeback formatter for the 5-stage MIPS pipeline.
- Captures the MEM-stage result (ALU value or raw load word) at the clock edge.
- Extracts and sign/zero-extends load bytes/halfwords (big-endian), checks load alignment.
- Drives the register file write port (we/waddr/wdata) and a retired-instruction counter.

Parameters:
- DATA_W, 32, data width (`RegBus width)
- ADDR_W, 5, register address width (`RegAddrBus width)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  pipeline clock
- clr  in  1  asynchronous active-high reset
- stall  in  1  hold MEM/WB contents (from hazard unit)
- flush  in  1  insert bubble (from exception/branch control)
- mem_valid  in  1  MEM stage holds a real instruction
- mem_we  in  1  instruction writes a GPR
- mem_waddr  in  ADDR_W  destination register
- mem_alu  in  DATA_W  ALU/link result
- mem_is_load  in  1  result comes from data memory
- mem_load_op  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; others treated as LW
- mem_addr_lo  in  2  effective address bits [1:0]
- mem_rdata  in  DATA_W  raw word from data memory, valid in MEM cycle
- wb_we  out  1  register file write enable
- wb_waddr  out  ADDR_W  register file write address
- wb_wdata  out  DATA_W  register file write data
- wb_misalign  out  1  one-cycle pulse: load alignment fault suppressed the write
- retired  out  CNT_W  count of instructions retired through WB

Behaviour:
- Reset (clr=1, async): wb_we=0, wb_waddr=0, wb_wdata=0, wb_misalign=0, retired=0, internal valid=0. Takes effect immediately, mid-operation included.
- Latency: one cycle. MEM inputs at edge N appear on wb_* after edge N and stay stable for the whole WB cycle.
- Edge priority, highest first: flush > stall > normal capture.
- flush=1: bubble. valid=0, wb_we=0, wb_misalign=0. Flush together with stall still bubbles.
- stall=1 (no flush): all registers hold, including wb_we. Repeated write of the same value is harmless. wb_misalign is cleared so it never exceeds one cycle. retired does not count.
- Normal capture: valid<=mem_valid.
- wb_we<=mem_valid & mem_we & (mem_waddr!=0) & ~fault.
- wb_waddr<=mem_waddr.
- retired increments by 1 when mem_valid is captured, including faulting loads. It wraps modulo 2^CNT_W.
- Load formatting when mem_is_load=1 (big-endian lanes):
  - Byte lane: addr_lo=0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0].
  - Halfword lane: addr_lo=0 -> [31:16], addr_lo=2 -> [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- When mem_is_load=0: wb_wdata<=mem_alu.
- Faults (loads only): LH/LHU with addr_lo[0]=1, or LW with addr_lo!=0.
  - On a fault: wb_we<=0, wb_misalign<=1 for exactly one cycle, wb_wdata<=0.
- Writes to $0 are never enabled, whatever mem_we is.
- wb_* are the only source of register file write data. Forwarding taps wb_wdata directly, with no extra latency.

Decomposition:
- Shared defines file (existing): DATA_W/ADDR_W via `RegBus/`RegAddrBus, `WriteEnable, and new load-op codes `LOAD_LW/`LOAD_LB/`LOAD_LBU/`LOAD_LH/`LOAD_LHU.
- One combinational sub-module, load_align: (load_op, addr_lo, rdata) -> (data, fault). It is unit-tested separately.
- Registers and counter live in mem_wb_stage.

Test Plan:
- Reset mid-stream: wb_we=1 pending, assert clr between edges -> outputs go to 0 immediately; retired=0; after release, first capture behaves normally.
- ALU pass-through: mem_valid=1, mem_we=1, waddr=5, alu=32'h12345678, is_load=0 -> next cycle wb_we=1, waddr=5, wdata=32'h12345678, retired increments.
- Load formatting with rdata=32'h80FF7F01:
  - LB addr 0 -> 32'hFFFFFF80
  - LBU addr 1 -> 32'h000000FF
  - LH addr 2 -> 32'h00007F01
  - LHU addr 0 -> 32'h000080FF
  - LW addr 0 -> 32'h80FF7F01
- Misaligned LW at addr_lo=2, waddr=7 -> wb_we=0, wb_misalign=1 for one cycle only, retired still increments.
- Stall/flush interaction:
  - stall for 3 cycles -> wb_* held, retired unchanged.
  - stall+flush same edge -> wb_we=0, retired unchanged.
- $0 write: mem_we=1, waddr=0, alu=32'hDEADBEEF -> wb_we=0; counter wraps from 32'hFFFFFFFF to 0 on next retire.
